// File: rtl/bcd_display_scanner_if.sv
// Bundles the BCD digit inputs and the multiplexed display outputs of the scanner.
// The master drives digits; the slave (the scanner) drives the display pins.
interface bcd_display_scanner_if;
    logic [3:0] bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0;
    logic       blank_lz;
    logic [6:0] seg;
    logic [6:0] an;
    logic [2:0] digit_idx;
    logic       frame_done;

    modport master (
        output bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0, blank_lz,
        input  seg, an, digit_idx, frame_done
    );

    modport slave (
        input  bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0, blank_lz,
        output seg, an, digit_idx, frame_done
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-digit seven-segment scanner with per-frame digit snapshot,
// leading-zero blanking and a dash for non-decimal codes.
module bcd_display_scanner #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    bcd_display_scanner_if.slave  io
);
    localparam int             CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            active_q, active_d;
    logic [6:0][3:0] snap_q, snap_d;
    logic            snap_blz_q, snap_blz_d;
    logic            frame_done_q, frame_done_d;

    logic            tick;
    logic            upper_zero;
    logic [6:0]      blank;
    logic [6:0]      en;
    logic [6:0]      pattern;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;  // non-decimal code shown as a dash
        endcase
        return p;
    endfunction

    always_comb begin
        tick         = (cnt_q == CNT_MAX);
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        active_d     = active_q;
        snap_d       = snap_q;
        snap_blz_d   = snap_blz_q;
        frame_done_d = 1'b0;
        if (tick) begin
            active_d = 1'b1;
            if (idx_q == 3'd6) begin
                // Frame boundary: latch digits so one frame never mixes two values.
                idx_d        = 3'd0;
                snap_d       = {io.bcd6, io.bcd5, io.bcd4, io.bcd3,
                                io.bcd2, io.bcd1, io.bcd0};
                snap_blz_d   = io.blank_lz;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = 6; k >= 0; k--) begin
            upper_zero = upper_zero && (snap_q[k] == 4'd0);
            blank[k]   = snap_blz_q && (k != 0) && upper_zero;
        end
        en = '0;
        if (active_q && !blank[idx_q])
            en = 7'd1 << idx_q;
        pattern = (en != 7'd0) ? seg_lut(snap_q[idx_q]) : 7'd0;
    end

    assign io.seg        = SEG_ACTIVE_LOW ? ~pattern : pattern;
    assign io.an         = SEG_ACTIVE_LOW ? ~en : en;
    assign io.digit_idx  = idx_q;
    assign io.frame_done = frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd6;
            active_q     <= 1'b0;
            snap_q       <= '0;
            snap_blz_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            snap_q       <= snap_d;
            snap_blz_q   <= snap_blz_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
